// File: rtl/weight_load_controller.sv
// Sequences filter weight loading: latches geometry on START, streams W packed
// words per filter into weight_buffer, holds each filter until consumed, then pulses DONE.
module weight_load_controller #(
  parameter int INPUT_WIDTH  = 32,
  parameter int MAX_DIM      = 5,
  parameter int CNT_WIDTH    = 16,
  parameter int FULL_TIMEOUT = 16
) (
  input  logic                   CLK,
  input  logic                   RESETN,
  input  logic                   START,
  input  logic [3:0]             CFG_R,
  input  logic [3:0]             CFG_S,
  input  logic [CNT_WIDTH-1:0]   CFG_NUM_FILTERS,
  input  logic                   S_VALID,
  input  logic [INPUT_WIDTH-1:0] S_DATA,
  output logic                   S_READY,
  output logic                   WB_WR_EN,
  output logic                   WB_WR_VALID,
  output logic [INPUT_WIDTH-1:0] WB_WR_DATA,
  output logic [3:0]             WB_PARAM_R,
  output logic [3:0]             WB_PARAM_S,
  input  logic                   WB_FULL,
  output logic                   WEIGHTS_VALID,
  input  logic                   WEIGHTS_CONSUMED,
  output logic [CNT_WIDTH-1:0]   FILTER_IDX,
  output logic                   BUSY,
  output logic                   DONE,
  output logic                   ERR,
  output logic [2:0]             DBG_STATE
);

  localparam int              TO_W      = $clog2(FULL_TIMEOUT + 1);
  localparam logic [3:0]      MAX_DIM_L = 4'(MAX_DIM);
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(FULL_TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_WAIT_FULL = 3'd2,
    ST_HOLD      = 3'd3,
    ST_FINISH    = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [3:0]            r_param_r;
  logic [3:0]            r_param_s;
  logic [3:0]            r_words;
  logic [3:0]            r_word_cnt;
  logic [CNT_WIDTH-1:0]  r_num;
  logic [CNT_WIDTH-1:0]  r_filter_idx;
  logic [TO_W-1:0]       r_to_cnt;
  logic                  r_err;
  logic                  r_wv;

  logic                  w_cfg_ok;
  logic [9:0]            w_prod;
  logic [3:0]            w_words_s5;
  logic [3:0]            w_words;
  logic                  w_start;
  logic                  w_start_ok;
  logic                  w_load;
  logic                  w_s_ready;
  logic                  w_accept;
  logic [3:0]            w_word_cnt_inc;
  logic                  w_last_word;
  logic                  w_timeout;
  logic                  w_consume;
  logic [CNT_WIDTH-1:0]  w_idx_inc;
  logic                  w_last_filter;

  assign w_cfg_ok = (CFG_R != 4'd0) && (CFG_S != 4'd0) && (CFG_R <= MAX_DIM_L) &&
                    (CFG_S <= MAX_DIM_L) && (CFG_R == CFG_S) && (CFG_NUM_FILTERS != '0);

  // Width-5 rows pack 40 bits each into 32-bit words, rounded up.
  assign w_prod     = {6'd0, CFG_R} * 10'd40;
  assign w_words_s5 = 4'((w_prod + 10'd31) >> 5);
  assign w_words    = (CFG_S <= 4'd4) ? CFG_R : w_words_s5;

  assign w_start    = (r_state == ST_IDLE) && START;
  assign w_start_ok = w_start && w_cfg_ok;

  // Upstream handshake: a word transfers on a rising edge where S_VALID and
  // S_READY are both high; the word is written straight through to the buffer.
  assign w_load         = (r_state == ST_LOAD);
  assign w_s_ready      = w_load && (r_word_cnt < r_words);
  assign w_accept       = w_s_ready && S_VALID;
  assign w_word_cnt_inc = r_word_cnt + 4'd1;
  assign w_last_word    = w_accept && (w_word_cnt_inc == r_words);

  assign w_timeout     = (r_state == ST_WAIT_FULL) && !WB_FULL && (r_to_cnt == TO_LAST);
  assign w_consume     = (r_state == ST_HOLD) && WEIGHTS_CONSUMED;
  assign w_idx_inc     = r_filter_idx + CNT_WIDTH'(1);
  assign w_last_filter = (w_idx_inc == r_num);

  always_ff @(posedge CLK) begin
    if (!RESETN) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:      if (w_start_ok) w_next = ST_LOAD;
      ST_LOAD:      if (w_last_word) w_next = ST_WAIT_FULL;
      ST_WAIT_FULL: begin
        if (WB_FULL)        w_next = ST_HOLD;
        else if (w_timeout) w_next = ST_IDLE;
      end
      ST_HOLD:      if (w_consume) w_next = w_last_filter ? ST_FINISH : ST_LOAD;
      ST_FINISH:    w_next = ST_IDLE;
      default:      w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      r_param_r    <= '0;
      r_param_s    <= '0;
      r_words      <= '0;
      r_word_cnt   <= '0;
      r_num        <= '0;
      r_filter_idx <= '0;
      r_to_cnt     <= '0;
      r_err        <= 1'b0;
      r_wv         <= 1'b0;
    end else begin
      // Any START seen in IDLE re-evaluates ERR; only a legal one re-latches the job.
      if (w_start) begin
        r_err <= !w_cfg_ok;
        if (w_cfg_ok) begin
          r_param_r    <= CFG_R;
          r_param_s    <= CFG_S;
          r_words      <= w_words;
          r_num        <= CFG_NUM_FILTERS;
          r_filter_idx <= '0;
          r_word_cnt   <= '0;
          r_to_cnt     <= '0;
        end
      end
      if (w_accept) r_word_cnt <= w_word_cnt_inc;
      if (r_state == ST_WAIT_FULL) begin
        if (WB_FULL) begin
          r_to_cnt <= '0;
        end else if (w_timeout) begin
          r_to_cnt <= '0;
          r_err    <= 1'b1;
        end else begin
          r_to_cnt <= r_to_cnt + TO_W'(1);
        end
      end
      r_wv <= (r_state == ST_HOLD) && !WEIGHTS_CONSUMED;
      if (w_consume) begin
        r_filter_idx <= w_idx_inc;
        r_word_cnt   <= '0;
      end
    end
  end

  assign S_READY       = w_s_ready;
  assign WB_WR_EN      = w_load;
  assign WB_WR_VALID   = w_load && S_VALID;
  assign WB_WR_DATA    = w_load ? S_DATA : '0;
  assign WB_PARAM_R    = r_param_r;
  assign WB_PARAM_S    = r_param_s;
  assign WEIGHTS_VALID = r_wv;
  assign FILTER_IDX    = r_filter_idx;
  assign BUSY          = (r_state != ST_IDLE);
  assign DONE          = (r_state == ST_FINISH);
  assign ERR           = r_err;
  assign DBG_STATE     = r_state;

endmodule

// File: tb/tb_weight_load_controller.sv
// Directed-sequence bench with randomized streaming for weight_load_controller;
// expected behaviour comes from a job-level model (words per filter, filter count).
module tb_weight_load_controller;

  logic        CLK = 1'b0;
  logic        RESETN;
  logic        START;
  logic [3:0]  CFG_R;
  logic [3:0]  CFG_S;
  logic [15:0] CFG_NUM_FILTERS;
  logic        S_VALID;
  logic [31:0] S_DATA;
  logic        S_READY;
  logic        WB_WR_EN;
  logic        WB_WR_VALID;
  logic [31:0] WB_WR_DATA;
  logic [3:0]  WB_PARAM_R;
  logic [3:0]  WB_PARAM_S;
  logic        WB_FULL;
  logic        WEIGHTS_VALID;
  logic        WEIGHTS_CONSUMED;
  logic [15:0] FILTER_IDX;
  logic        BUSY;
  logic        DONE;
  logic        ERR;
  logic [2:0]  DBG_STATE;

  weight_load_controller dut (
    .CLK(CLK), .RESETN(RESETN), .START(START), .CFG_R(CFG_R), .CFG_S(CFG_S),
    .CFG_NUM_FILTERS(CFG_NUM_FILTERS), .S_VALID(S_VALID), .S_DATA(S_DATA),
    .S_READY(S_READY), .WB_WR_EN(WB_WR_EN), .WB_WR_VALID(WB_WR_VALID),
    .WB_WR_DATA(WB_WR_DATA), .WB_PARAM_R(WB_PARAM_R), .WB_PARAM_S(WB_PARAM_S),
    .WB_FULL(WB_FULL), .WEIGHTS_VALID(WEIGHTS_VALID),
    .WEIGHTS_CONSUMED(WEIGHTS_CONSUMED), .FILTER_IDX(FILTER_IDX), .BUSY(BUSY),
    .DONE(DONE), .ERR(ERR), .DBG_STATE(DBG_STATE)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  // job model state
  int m_r, m_s, m_n, m_w, m_idx;

  function automatic int words_for(input int r, input int s);
    if (s <= 4) return r;
    return (r * 40 + 31) / 32;
  endfunction

  function automatic bit cfg_legal(input int r, input int s, input int n);
    return (r >= 1) && (s >= 1) && (r <= 5) && (s <= 5) && (r == s) && (n != 0);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero();
    chk("rst_s_ready", S_READY, 0);
    chk("rst_wr_en", WB_WR_EN, 0);
    chk("rst_wr_valid", WB_WR_VALID, 0);
    chk("rst_wr_data", WB_WR_DATA, 0);
    chk("rst_param_r", WB_PARAM_R, 0);
    chk("rst_param_s", WB_PARAM_S, 0);
    chk("rst_wv", WEIGHTS_VALID, 0);
    chk("rst_idx", FILTER_IDX, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_err", ERR, 0);
  endtask

  // driver tasks
  task automatic start_job(input int r, input int s, input int n, output bit legal);
    @(negedge CLK);
    START = 1'b1; CFG_R = 4'(r); CFG_S = 4'(s); CFG_NUM_FILTERS = 16'(n);
    S_VALID = 1'b0; WEIGHTS_CONSUMED = 1'b0; WB_FULL = 1'b0;
    @(negedge CLK);
    START = 1'b0;
    #1;
    legal = cfg_legal(r, s, n);
    chk("start_err", ERR, !legal);
    chk("start_busy", BUSY, legal);
    chk("start_s_ready", S_READY, legal);
    chk("start_done", DONE, 0);
    if (legal) begin
      m_r = r; m_s = s; m_n = n; m_w = words_for(r, s); m_idx = 0;
      chk("start_param_r", WB_PARAM_R, 4'(r));
      chk("start_param_s", WB_PARAM_S, 4'(s));
      chk("start_idx", FILTER_IDX, 0);
    end
  endtask

  task automatic load_filter(input int prob, input bit spurious, input int nwords);
    int acc; int cyc; bit have; logic [31:0] pend; logic [31:0] exp_w;
    acc = 0; cyc = 0; have = 1'b0; pend = '0;
    while (acc < nwords && cyc < 300) begin
      @(negedge CLK);
      cyc++;
      START = 1'b0; WEIGHTS_CONSUMED = 1'b0;
      if (spurious && cyc == 1) begin
        START = 1'b1; CFG_R = 4'd2; CFG_S = 4'd2; CFG_NUM_FILTERS = 16'd9;
        WEIGHTS_CONSUMED = 1'b1;
      end
      if (!have && $urandom_range(0, 99) < prob) begin
        pend = $urandom; have = 1'b1; exp_q.push_back(pend);
      end
      S_VALID = have;
      S_DATA  = have ? pend : $urandom;
      #1;
      chk("load_s_ready", S_READY, 1);
      chk("load_wr_en", WB_WR_EN, 1);
      chk("load_wr_valid", WB_WR_VALID, S_VALID);
      chk("load_param_r", WB_PARAM_R, 4'(m_r));
      chk("load_param_s", WB_PARAM_S, 4'(m_s));
      chk("load_idx", FILTER_IDX, 16'(m_idx));
      chk("load_wv", WEIGHTS_VALID, 0);
      if (have) begin
        exp_w = exp_q.pop_front();
        chk("wr_data", WB_WR_DATA, exp_w);
        acc++;
        have = 1'b0;
      end
    end
    chk("load_word_count", acc, nwords);
  endtask

  task automatic hold_and_consume(input bit is_last);
    int d;
    d = $urandom_range(0, 3);
    repeat (d) begin
      @(negedge CLK);
      S_VALID = 1'b1; S_DATA = $urandom; WB_FULL = 1'b0;
      #1;
      chk("wait_no_ready", S_READY, 0);
      chk("wait_no_wr_valid", WB_WR_VALID, 0);
      chk("wait_wv", WEIGHTS_VALID, 0);
      chk("wait_busy", BUSY, 1);
    end
    @(negedge CLK);
    WB_FULL = 1'b1; S_VALID = 1'b1; S_DATA = $urandom;
    #1;
    chk("full_no_ready", S_READY, 0);
    chk("full_wv", WEIGHTS_VALID, 0);
    @(negedge CLK);
    S_VALID = 1'b0;
    #1;
    chk("hold_entry_wv", WEIGHTS_VALID, 0);
    chk("hold_no_ready", S_READY, 0);
    @(negedge CLK);
    #1;
    chk("hold_wv_rise", WEIGHTS_VALID, 1);
    chk("hold_idx", FILTER_IDX, 16'(m_idx));
    repeat ($urandom_range(0, 2)) begin
      @(negedge CLK);
      #1;
      chk("hold_wv_steady", WEIGHTS_VALID, 1);
    end
    @(negedge CLK);
    WEIGHTS_CONSUMED = 1'b1;
    @(negedge CLK);
    WEIGHTS_CONSUMED = 1'b0; WB_FULL = 1'b0;
    m_idx++;
    #1;
    chk("consume_wv_drop", WEIGHTS_VALID, 0);
    chk("consume_idx", FILTER_IDX, 16'(m_idx));
    chk("consume_done", DONE, is_last);
    chk("consume_busy", BUSY, 1);
    chk("consume_next_ready", S_READY, !is_last);
    if (is_last) begin
      @(negedge CLK);
      #1;
      chk("finish_done_drop", DONE, 0);
      chk("finish_busy", BUSY, 0);
      chk("finish_idx", FILTER_IDX, 16'(m_n));
    end
  endtask

  task automatic run_job(input int r, input int s, input int n, input int prob, input bit spurious);
    bit legal;
    start_job(r, s, n, legal);
    if (legal) begin
      for (int k = 0; k < n; k++) begin
        load_filter(prob, spurious && (k == 0), m_w);
        hold_and_consume(k == n - 1);
      end
    end
  endtask

  initial begin
    bit legal;
    RESETN = 1'b0; START = 1'b0; CFG_R = 4'd0; CFG_S = 4'd0; CFG_NUM_FILTERS = 16'd0;
    S_VALID = 1'b1; S_DATA = 32'h1234_5678; WB_FULL = 1'b0; WEIGHTS_CONSUMED = 1'b0;
    m_r = 0; m_s = 0; m_n = 0; m_w = 0; m_idx = 0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    #1;
    chk_all_zero();
    RESETN = 1'b1;
    S_VALID = 1'b0;

    // 5x5, two filters, source always valid: 7 words per filter
    run_job(5, 5, 2, 100, 1'b0);
    chk("words_5x5", m_w, 7);

    // 3x3, three filters, 50% source valid
    run_job(3, 3, 3, 50, 1'b0);

    // illegal geometries leave the controller idle with ERR set
    start_job(4, 3, 1, legal);
    @(negedge CLK);
    #1;
    chk("illegal_idle_ready", S_READY, 0);
    chk("illegal_idle_busy", BUSY, 0);
    start_job(6, 6, 2, legal);
    start_job(2, 2, 0, legal);
    @(negedge CLK);
    #1;
    chk("illegal_err_sticky", ERR, 1);
    run_job(1, 1, 1, 100, 1'b0);

    // 2x2 with WB_FULL never asserted: timeout after 16 cycles
    start_job(2, 2, 1, legal);
    load_filter(100, 1'b0, 2);
    repeat (16) begin
      @(negedge CLK);
      S_VALID = 1'b1; S_DATA = $urandom; WB_FULL = 1'b0;
      #1;
      chk("timeout_busy", BUSY, 1);
      chk("timeout_no_ready", S_READY, 0);
      chk("timeout_err_low", ERR, 0);
    end
    @(negedge CLK);
    S_VALID = 1'b0;
    #1;
    chk("timeout_idle", BUSY, 0);
    chk("timeout_err", ERR, 1);
    chk("timeout_done", DONE, 0);

    // 4x4 with spurious START/CONSUMED during LOAD
    run_job(4, 4, 2, 70, 1'b1);

    // reset after 2 of 4 words, then restart from word 0
    start_job(4, 4, 1, legal);
    load_filter(100, 1'b0, 2);
    @(negedge CLK);
    RESETN = 1'b0; S_VALID = 1'b1; S_DATA = 32'hDEAD_BEEF;
    @(negedge CLK);
    #1;
    chk_all_zero();
    RESETN = 1'b1;
    S_VALID = 1'b0;
    exp_q.delete();
    run_job(4, 4, 1, 100, 1'b0);

    // a few random legal jobs
    for (int j = 0; j < 3; j++) begin
      int r;
      r = $urandom_range(1, 5);
      run_job(r, r, $urandom_range(1, 2), $urandom_range(30, 100), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
